// File: rtl/ulticolor_pkg.sv
// Shared definitions for the ulticolor bank controller: register offsets,
// CTRL bit positions and the control register layout.
package ulticolor_pkg;

  typedef enum logic [1:0] {
    OFF_BANK_LO = 2'd0,
    OFF_BANK_HI = 2'd1,
    OFF_CTRL    = 2'd2,
    OFF_STATUS  = 2'd3
  } reg_off_t;

  localparam int unsigned CTRL_FLIP = 0;
  localparam int unsigned CTRL_WP   = 1;

  typedef struct packed {
    logic wp;
    logic flip;
  } ctrl_t;

endpackage

// File: rtl/ulticolor_bus_sync.sv
// Synchronises the asynchronous color-bus strobes into the clock domain,
// samples address/data during a write and emits a one-clock commit strobe.
module ulticolor_bus_sync #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we_n,
  input  logic                  ce_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] sample_addr,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic                  commit
);

  logic we_s1, we_s2, ce_s1, ce_s2;
  logic [1:0] fill;
  logic armed;
  logic we_d;
  logic we_eff;

  // After reset a write already in progress is ignored: synced we is held
  // high until the pins have been seen high once, so only a fresh falling
  // edge can start a new capture.
  assign we_eff = we_s2 | ~armed;
  assign commit = we_eff & ~we_d & ~ce_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      we_s1       <= 1'b1;
      we_s2       <= 1'b1;
      ce_s1       <= 1'b1;
      ce_s2       <= 1'b1;
      fill        <= '0;
      armed       <= 1'b0;
      we_d        <= 1'b1;
      sample_addr <= '0;
      sample_data <= '0;
    end else begin
      we_s1 <= we_n;
      we_s2 <= we_s1;
      ce_s1 <= ce_n;
      ce_s2 <= ce_s1;
      fill  <= {fill[0], 1'b1};
      if (fill[1] && we_s2)
        armed <= 1'b1;
      we_d <= we_eff;
      if (!we_eff && !ce_s2) begin
        sample_addr <= address;
        sample_data <= data_in;
      end
    end
  end

endmodule

// File: rtl/ulti_color_bank_ctrl.sv
// Color-RAM bank controller: register block, frame-synchronised bank flip and
// lane muxing. Define ULTICOLOR_READBACK_EN to read registers back on the bus.
module ulti_color_bank_ctrl
  import ulticolor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned LANE_BITS  = 1,
  parameter int unsigned BANK_BITS  = 7
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             address_color,
  input  logic [DATA_WIDTH-1:0]             data_color_i,
  output logic [DATA_WIDTH-1:0]             data_color_o,
  output logic                              data_color_oe,
  input  logic                              _ce_color,
  input  logic                              _we_color,
  input  logic                              frame_sync,
  output logic [BANK_BITS-LANE_BITS-1:0]    bank,
  input  logic [(2**LANE_BITS)*DATA_WIDTH-1:0] mem_data_i,
  output logic [(2**LANE_BITS)*DATA_WIDTH-1:0] mem_data_o,
  output logic [(2**LANE_BITS)-1:0]         mem_data_oe,
  output logic                              _ce_mem,
  output logic                              _we_mem,
  output logic [(2**LANE_BITS)-1:0]         _lane_n
);

  localparam int unsigned LANES = 2**LANE_BITS;

  logic [ADDR_WIDTH-1:0]   sample_addr;
  logic [DATA_WIDTH-1:0]   sample_data;
  logic                    commit;

  logic [BANK_BITS-1:0]    active_bank, pending_bank, bank_wr;
  logic [2*DATA_WIDTH-1:0] pend_ext;
  ctrl_t                   ctrl;
  logic                    pend_flag;

  logic                    reg_hit_s, reg_hit_p, wp_block;
  reg_off_t                off_s, off_p;
  logic [LANE_BITS-1:0]    lane;
  logic [DATA_WIDTH-1:0]   mem_lane;

  ulticolor_bus_sync #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bus_sync (
    .clock       (clock),
    .reset       (reset),
    .we_n        (_we_color),
    .ce_n        (_ce_color),
    .address     (address_color),
    .data_in     (data_color_i),
    .sample_addr (sample_addr),
    .sample_data (sample_data),
    .commit      (commit)
  );

  assign reg_hit_s = &sample_addr[ADDR_WIDTH-1:2];
  assign off_s     = reg_off_t'(sample_addr[1:0]);
  assign reg_hit_p = &address_color[ADDR_WIDTH-1:2];
  assign off_p     = reg_off_t'(address_color[1:0]);

  // Bank halves are merged on a 2*DATA_WIDTH view of pending_bank, then cut
  // back to BANK_BITS so surplus BANK_HI data bits drop out.
  assign pend_ext = (2*DATA_WIDTH)'(pending_bank);
  assign bank_wr  = (off_s == OFF_BANK_LO)
                  ? BANK_BITS'({pend_ext[2*DATA_WIDTH-1:DATA_WIDTH], sample_data})
                  : BANK_BITS'({sample_data, pend_ext[DATA_WIDTH-1:0]});

  // Later assignments win: a bank commit coinciding with frame_sync still
  // leaves pend_flag set, after the transfer took the old pending_bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      active_bank  <= '0;
      pending_bank <= '0;
      ctrl         <= '0;
      pend_flag    <= 1'b0;
    end else begin
      if (frame_sync && pend_flag) begin
        active_bank <= pending_bank;
        pend_flag   <= 1'b0;
      end
      if (commit && reg_hit_s) begin
        case (off_s)
          OFF_BANK_LO, OFF_BANK_HI: begin
            if (ctrl.flip) begin
              pending_bank <= bank_wr;
              pend_flag    <= 1'b1;
            end else begin
              active_bank  <= bank_wr;
              pending_bank <= bank_wr;
            end
          end
          OFF_CTRL: begin
            ctrl.flip <= sample_data[CTRL_FLIP];
            ctrl.wp   <= sample_data[CTRL_WP];
            if (!sample_data[CTRL_FLIP] && pend_flag) begin
              active_bank <= pending_bank;
              pend_flag   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign lane     = active_bank[BANK_BITS-1 -: LANE_BITS];
  assign bank     = active_bank[BANK_BITS-LANE_BITS-1:0];
  assign wp_block = ctrl.wp & ~reg_hit_p;
  assign mem_lane = mem_data_i[lane*DATA_WIDTH +: DATA_WIDTH];

  assign mem_data_o    = {LANES{data_color_i}};
  assign _ce_mem       = _ce_color;
  assign _we_mem       = wp_block | _we_color;
  assign data_color_oe = ~_ce_color & _we_color;

  always_comb begin
    mem_data_oe       = '0;
    mem_data_oe[lane] = ~_ce_color & ~_we_color & ~wp_block;
    _lane_n           = '1;
    _lane_n[lane]     = 1'b0;
  end

  always_comb begin
    data_color_o = mem_lane;
    if (reg_hit_p) begin
`ifdef ULTICOLOR_READBACK_EN
      case (off_p)
        OFF_BANK_LO: data_color_o = pend_ext[DATA_WIDTH-1:0];
        OFF_BANK_HI: data_color_o = pend_ext[2*DATA_WIDTH-1:DATA_WIDTH];
        OFF_CTRL:    data_color_o = DATA_WIDTH'(ctrl);
        default:     data_color_o = DATA_WIDTH'(pend_flag);
      endcase
`else
      if (off_p == OFF_STATUS)
        data_color_o = DATA_WIDTH'(pend_flag);
`endif
    end
  end

endmodule

// File: tb/tb_ulti_color_bank_ctrl.sv
// Scoreboard bench for ulti_color_bank_ctrl: stimulus queues expected values
// tagged with the cycle they apply to; a negedge monitor pops and compares.
module tb_ulti_color_bank_ctrl;

  localparam int S_BANK  = 0;
  localparam int S_LANEN = 1;
  localparam int S_DOUT  = 2;
  localparam int S_DOE   = 3;
  localparam int S_WEMEM = 4;
  localparam int S_MOE   = 5;
  localparam int S_MDO   = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] address_color;
  logic [3:0] data_color_i;
  logic [3:0] data_color_o;
  logic       data_color_oe;
  logic       _ce_color;
  logic       _we_color;
  logic       frame_sync;
  logic [5:0] bank;
  logic [7:0] mem_data_i;
  logic [7:0] mem_data_o;
  logic [1:0] mem_data_oe;
  logic       _ce_mem;
  logic       _we_mem;
  logic [1:0] _lane_n;

  typedef struct {
    string       name;
    int          sel;
    int          cyc;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  ulti_color_bank_ctrl #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (4),
    .LANE_BITS  (1),
    .BANK_BITS  (7)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address_color (address_color),
    .data_color_i  (data_color_i),
    .data_color_o  (data_color_o),
    .data_color_oe (data_color_oe),
    ._ce_color     (_ce_color),
    ._we_color     (_we_color),
    .frame_sync    (frame_sync),
    .bank          (bank),
    .mem_data_i    (mem_data_i),
    .mem_data_o    (mem_data_o),
    .mem_data_oe   (mem_data_oe),
    ._ce_mem       (_ce_mem),
    ._we_mem       (_we_mem),
    ._lane_n       (_lane_n)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_BANK:  return 32'(bank);
      S_LANEN: return 32'(_lane_n);
      S_DOUT:  return 32'(data_color_o);
      S_DOE:   return 32'(data_color_oe);
      S_WEMEM: return 32'(_we_mem);
      S_MOE:   return 32'(mem_data_oe);
      default: return 32'(mem_data_o);
    endcase
  endfunction

  function automatic void expect_at(input string n, input int sel, input int c,
                                    input logic [31:0] e);
    chk_t item;
    int   i;
    item.name = n;
    item.sel  = sel;
    item.cyc  = c;
    item.exp  = e;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, item);
  endfunction

  always @(negedge clock) begin : monitor
    chk_t c;
    logic [31:0] a;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      c = q.pop_front();
      checks++;
      if (c.cyc < cyc) begin
        failures++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", c.name, c.cyc, cyc);
      end else begin
        a = actual(c.sel);
        if (a !== c.exp) begin
          failures++;
          $display("FAIL %s @%0d: actual 0x%0h required 0x%0h", c.name, cyc, a, c.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [3:0] d,
                           input logic [1:0] moe, input logic wem, input logic fs,
                           input logic [5:0] b_before, input logic [5:0] b_after,
                           input logic [1:0] ln_after);
    int r;
    tick();
    address_color = a;
    data_color_i  = d;
    _ce_color     = 1'b0;
    tick();
    _we_color = 1'b0;
    expect_at("wr_we_mem", S_WEMEM, cyc, 32'(wem));
    expect_at("wr_mem_oe", S_MOE, cyc, 32'(moe));
    expect_at("wr_mem_do", S_MDO, cyc, 32'({d, d}));
    tick(); tick(); tick();
    _we_color = 1'b1;
    r = cyc;
    expect_at("bank_pre", S_BANK, r + 2, 32'(b_before));
    expect_at("bank_post", S_BANK, r + 3, 32'(b_after));
    expect_at("lane_n_post", S_LANEN, r + 3, 32'(ln_after));
    tick(); tick();
    if (fs) frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    _ce_color  = 1'b1;
    tick(); tick();
  endtask

  task automatic read_chk(input string n, input logic [9:0] a, input logic [3:0] e);
    tick();
    address_color = a;
    _ce_color     = 1'b0;
    expect_at(n, S_DOUT, cyc, 32'(e));
    expect_at("rd_oe", S_DOE, cyc, 32'd1);
    tick();
    _ce_color = 1'b1;
    expect_at("idle_oe", S_DOE, cyc, 32'd0);
  endtask

  task automatic frame_pulse(input logic [5:0] e);
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    expect_at("frame_bank", S_BANK, cyc, 32'(e));
  endtask

  initial begin
    int r;
    reset         = 1'b1;
    _ce_color     = 1'b1;
    _we_color     = 1'b1;
    address_color = '0;
    data_color_i  = '0;
    frame_sync    = 1'b0;
    mem_data_i    = 8'hC7;
    tick(); tick(); tick();
    reset = 1'b0;
    expect_at("rst_bank", S_BANK, cyc, 32'd0);
    expect_at("rst_lane_n", S_LANEN, cyc, 32'b10);
    expect_at("rst_we_mem", S_WEMEM, cyc, 32'd1);
    expect_at("rst_doe", S_DOE, cyc, 32'd0);
    expect_at("rst_moe", S_MOE, cyc, 32'd0);
    tick(); tick(); tick(); tick();

    // direct bank writes
    bus_write(10'h3FC, 4'h5, 2'b01, 1'b0, 1'b0, 6'h00, 6'h05, 2'b10);
    bus_write(10'h3FD, 4'h4, 2'b01, 1'b0, 1'b0, 6'h05, 6'h05, 2'b01);
    read_chk("rd_mem_lane1", 10'h010, 4'hC);
    read_chk("rd_status0", 10'h3FF, 4'h0);

    // flip mode
    bus_write(10'h3FE, 4'h1, 2'b10, 1'b0, 1'b0, 6'h05, 6'h05, 2'b01);
    bus_write(10'h3FC, 4'hA, 2'b10, 1'b0, 1'b0, 6'h05, 6'h05, 2'b01);
    read_chk("rd_status_pend", 10'h3FF, 4'h1);
    frame_pulse(6'h0A);
    read_chk("rd_status_clr", 10'h3FF, 4'h0);

    // frame_sync coinciding with a bank commit
    bus_write(10'h3FC, 4'h6, 2'b10, 1'b0, 1'b0, 6'h0A, 6'h0A, 2'b01);
    bus_write(10'h3FC, 4'h3, 2'b10, 1'b0, 1'b1, 6'h0A, 6'h06, 2'b01);
    read_chk("rd_status_same", 10'h3FF, 4'h1);
    frame_pulse(6'h03);
    read_chk("rd_status_clr2", 10'h3FF, 4'h0);

    // clearing FLIP while a flip is pending
    bus_write(10'h3FC, 4'h9, 2'b10, 1'b0, 1'b0, 6'h03, 6'h03, 2'b01);
    bus_write(10'h3FE, 4'h0, 2'b10, 1'b0, 1'b0, 6'h03, 6'h09, 2'b01);
    read_chk("rd_status_ctrl", 10'h3FF, 4'h0);

    // write protect
    bus_write(10'h3FE, 4'h2, 2'b10, 1'b0, 1'b0, 6'h09, 6'h09, 2'b01);
    bus_write(10'h000, 4'h7, 2'b00, 1'b1, 1'b0, 6'h09, 6'h09, 2'b01);
    bus_write(10'h3FC, 4'h1, 2'b10, 1'b0, 1'b0, 6'h09, 6'h01, 2'b01);

    // glitch: ce rises one clock before we
    tick();
    address_color = 10'h3FC;
    data_color_i  = 4'hE;
    _ce_color     = 1'b0;
    tick();
    _we_color = 1'b0;
    tick(); tick(); tick();
    _ce_color = 1'b1;
    tick();
    _we_color = 1'b1;
    r = cyc;
    expect_at("glitch_bank", S_BANK, r + 3, 32'h01);
    expect_at("glitch_bank2", S_BANK, r + 4, 32'h01);
    expect_at("glitch_lane_n", S_LANEN, r + 4, 32'b01);
    tick(); tick(); tick(); tick(); tick();

    // reset in the middle of a write
    tick();
    address_color = 10'h3FC;
    data_color_i  = 4'hB;
    _ce_color     = 1'b0;
    tick();
    _we_color = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    expect_at("midrst_bank", S_BANK, cyc, 32'h00);
    tick(); tick(); tick();
    _we_color = 1'b1;
    r = cyc;
    expect_at("midrst_bank_post", S_BANK, r + 3, 32'h00);
    expect_at("midrst_bank_late", S_BANK, r + 4, 32'h00);
    expect_at("midrst_lane_n", S_LANEN, r + 4, 32'b10);
    tick(); tick(); tick();
    _ce_color = 1'b1;
    tick(); tick();
    read_chk("midrst_status", 10'h3FF, 4'h0);

    // register readback of CTRL
    bus_write(10'h3FE, 4'h3, 2'b01, 1'b0, 1'b0, 6'h00, 6'h00, 2'b10);
`ifdef ULTICOLOR_READBACK_EN
    read_chk("rd_ctrl", 10'h3FE, 4'h3);
`else
    read_chk("rd_ctrl_mem", 10'h3FE, 4'h7);
`endif

    for (int i = 0; i < 30 && q.size() > 0; i++) tick();
    while (q.size() > 0) begin
      chk_t c;
      c = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: never checked (due cycle %0d)", c.name, c.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ulti_color_bank_ctrl.md
Name: ulti_color_bank_ctrl

Overview:
- Parametrised, clocked successor to the color-RAM bank controller.
- Sits between the C64 color-RAM socket and a wider external SRAM; maps a 2^ADDR_WIDTH x DATA_WIDTH window onto one of 2^BANK_BITS banks spread across LANES memory data lanes.
- Adds write synchronisation, a control register, a write-protect mode, and a frame-synchronised bank flip that double-buffers the bank change.

Parameters:
ADDR_WIDTH, 10, color bus address width; register block occupies the top 4 addresses (REG_BASE = 2^ADDR_WIDTH-4)
DATA_WIDTH, 4, color bus and per-lane memory data width
LANE_BITS, 1, log2 of lane count; LANES = 2^LANE_BITS
BANK_BITS, 7, total bank register width including lane select in MSBs; constraint LANE_BITS < BANK_BITS <= 2*DATA_WIDTH

Ports:
clock  in  1  system clock, >= 8x bus cycle rate
reset  in  1  synchronous, active-high
address_color  in  ADDR_WIDTH  color bus address
data_color_i  in  DATA_WIDTH  color bus write data
data_color_o  out  DATA_WIDTH  color bus read data
data_color_oe  out  1  drive enable for data_color
_ce_color  in  1  chip enable, active low, asynchronous to clock
_we_color  in  1  write enable, active low, asynchronous to clock
frame_sync  in  1  single-cycle pulse at vertical blank, clock domain
bank  out  BANK_BITS-LANE_BITS  memory bank address = active_bank low bits
mem_data_i  in  LANES*DATA_WIDTH  memory read data, lane n at [n*DATA_WIDTH +: DATA_WIDTH]
mem_data_o  out  LANES*DATA_WIDTH  memory write data, color data replicated on every lane
mem_data_oe  out  LANES  per-lane drive enable
_ce_mem  out  1  = _ce_color
_we_mem  out  1  memory write enable, active low
_lane_n  out  LANES  lane byte-enables, active low; only the selected lane is low

Behaviour:
- Reset:
  - active_bank = 0, pending_bank = 0, ctrl = 0, pend_flag = 0, sync stages = idle (we/ce high).
  - Combinational outputs follow from these values.
- Memory path (combinational):
  - lane = active_bank[BANK_BITS-1 -: LANE_BITS].
  - mem_data_oe[lane] = !_ce_color & !_we_color & !wp_block; all other lanes 0.
  - data_color_oe = !_ce_color & _we_color.
  - data_color_o = selected lane of mem_data_i, except where the register readback below applies.
  - wp_block = ctrl.WP & address below REG_BASE; when set, _we_mem = 1, otherwise _we_mem = _we_color.
- Write capture:
  - _we_color and _ce_color pass through a 2-flop synchroniser.
  - address_color and data_color_i are registered every clock while synced we and ce are both low; the last sample is held.
  - A commit fires on the synced rising edge of we while synced ce is low.
  - Latency: register state changes 3 clocks after the _we_color rising edge at the pins.
- Register map (offset from REG_BASE); register writes are also forwarded to memory:
  - 0 BANK_LO: bank[DATA_WIDTH-1:0]
  - 1 BANK_HI: bank[BANK_BITS-1:DATA_WIDTH]; unused data bits ignored
  - 2 CTRL: bit0 FLIP, bit1 WP; other bits ignored
  - 3 STATUS: bit0 pend_flag; read-only, writes ignored
- FLIP=0: a BANK_LO/BANK_HI commit updates active_bank and pending_bank directly.
- FLIP=1: the commit updates pending_bank only and sets pend_flag.
- frame_sync with pend_flag=1: active_bank <= pending_bank; pend_flag <= 0. With pend_flag=0, frame_sync has no effect.
- frame_sync in the same cycle as a bank commit: the transfer uses the pre-write pending_bank; the write then loads pending_bank and pend_flag stays 1.
- CTRL commit clearing FLIP while pend_flag=1: in that same cycle, active_bank <= pending_bank and pend_flag <= 0.
- Bus glitch (_ce rises before _we): no commit, because synced ce is high at the we edge.
- Reset mid-write: the write is discarded, and the sampled we stays high until a fresh falling edge.

Optional Feature:
- ULTICOLOR_READBACK_EN defined: reads at offsets 0..3 return {pending_bank slice, ctrl, status} from the block, zero-padded; the memory lane is not driven onto data_color_o.
- Undefined: offsets 0..2 read from memory; offset 3 still returns STATUS.

Decomposition:
- Package ulticolor_pkg holds: register offset constants (OFF_BANK_LO/HI, OFF_CTRL, OFF_STATUS), CTRL bit indices (CTRL_FLIP, CTRL_WP), and a ctrl_t packed struct.
- One sub-module, ulticolor_bus_sync: synchroniser, address/data sample and commit-strobe generation.
- Top-level: register file, flip logic and lane muxing.

Test Plan:
- Reset, then write 0x5 to BANK_LO and 0x4 to BANK_HI with FLIP=0 -> 3 clocks after each _we rise, active_bank=0x45, bank=0x05, _lane_n=2'b01 (lane1 low).
- Write CTRL=0x1, then BANK_LO=0xA -> active unchanged, STATUS reads 1; pulse frame_sync -> bank low nibble=0xA next clock, STATUS=0.
- FLIP=1 with pending write, frame_sync in the same clock as a second BANK_LO=0x3 commit -> active gets the first value, pending=0x3, pend_flag=1.
- CTRL=0x2 (WP) with write to address 0x000 -> _we_mem stays 1, mem_data_oe=0; write to REG_BASE+0 still updates bank.
- _ce_color rises 1 clock before _we_color -> no register change; reset asserted mid-write -> all registers 0, no commit.
- ULTICOLOR_READBACK_EN on: read REG_BASE+2 after CTRL=0x3 -> data_color_o=0x3, mem lane ignored.
